// File: rtl/playback.sv
// SRAM-to-codec audio playback: streams 16-bit words MSB first on AUD_DACDAT, one word per LRCK slot.
// Build option PLAYBACK_LOOP_EN: wrap to START_ADDR after end_addr instead of stopping.
module playback #(
    parameter logic [19:0] START_ADDR = 20'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AUD_BCLK,
    input  logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic [19:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ,
    output logic        SRAM_OE,
    output logic        SRAM_WE,
    output logic        SRAM_CE,
    output logic        SRAM_LB,
    output logic        SRAM_UB,
    input  logic [19:0] end_addr,
    input  logic        play_btn,
    input  logic        stop_btn
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_bclk_meta;
    logic        r_bclk_sync;
    logic        r_bclk_prev;
    logic        r_lrck_meta;
    logic        r_lrck_sync;
    logic        r_lrck_last;

    logic [15:0] r_shift;
    logic [4:0]  r_bitcnt;
    logic        r_dacdat;
    logic [19:0] r_addr;
    logic        r_adv;
    logic        r_sram_off;

    logic        w_bclk_fall;
    logic        w_slot_start;
    logic        w_left_start;
    logic        w_load;
    logic        w_empty;
    logic        w_last_done;
    logic [20:0] w_span;
    logic [19:0] w_next_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_prev <= 1'b0;
            r_lrck_meta <= 1'b0;
            r_lrck_sync <= 1'b0;
            r_lrck_last <= 1'b0;
        end else begin
            r_bclk_meta <= AUD_BCLK;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_prev <= r_bclk_sync;
            r_lrck_meta <= AUD_DACLRCK;
            r_lrck_sync <= r_lrck_meta;
            if (w_bclk_fall) begin
                r_lrck_last <= r_lrck_sync;
            end
        end
    end

    // LRCK is judged only at BCLK falls, where the codec moves it.
    assign w_bclk_fall  = r_bclk_prev & ~r_bclk_sync;
    assign w_slot_start = w_bclk_fall & (r_lrck_sync != r_lrck_last);
    assign w_left_start = w_slot_start & ~r_lrck_sync;

    // Borrow out of end_addr - START_ADDR flags an empty recording.
    assign w_span  = {1'b0, end_addr} - {1'b0, START_ADDR};
    assign w_empty = w_span[20];

`ifdef PLAYBACK_LOOP_EN
    assign w_last_done = 1'b0;
    assign w_next_addr = (r_addr >= end_addr) ? START_ADDR : r_addr + 20'd1;
`else
    logic r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_next_state == IDLE) begin
            r_done <= 1'b0;
        end else if (w_load) begin
            r_done <= (r_addr >= end_addr);
        end
    end

    assign w_last_done = r_done;
    assign w_next_addr = (r_addr >= end_addr) ? r_addr : r_addr + 20'd1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (stop_btn && !play_btn) begin
                    w_next_state = ALIGN;
                end
            end
            ALIGN: begin
                if (!stop_btn) begin
                    w_next_state = IDLE;
                end else if (w_slot_start && w_empty) begin
                    w_next_state = IDLE;
                end else if (w_left_start) begin
                    w_next_state = PLAY;
                end
            end
            PLAY: begin
                if (!stop_btn) begin
                    w_next_state = IDLE;
                end else if (w_slot_start && w_last_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_load = w_slot_start && (w_next_state == PLAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= START_ADDR;
            r_dacdat   <= 1'b0;
            r_shift    <= 16'd0;
            r_bitcnt   <= 5'd0;
            r_adv      <= 1'b0;
            r_sram_off <= 1'b1;
        end else if (w_next_state == IDLE) begin
            r_addr     <= START_ADDR;
            r_dacdat   <= 1'b0;
            r_shift    <= 16'd0;
            r_bitcnt   <= 5'd0;
            r_adv      <= 1'b0;
            r_sram_off <= 1'b1;
        end else begin
            r_sram_off <= 1'b0;
            r_adv      <= w_load;
            // Address moves one clk after the load so SRAM_DQ is sampled stable.
            if (r_adv) begin
                r_addr <= w_next_addr;
            end
            if (w_load) begin
                r_shift  <= SRAM_DQ;
                r_bitcnt <= 5'd0;
                r_dacdat <= 1'b0;
            end else if (w_bclk_fall && (r_state == PLAY)) begin
                if (r_bitcnt != 5'd16) begin
                    r_dacdat <= r_shift[15];
                    r_shift  <= {r_shift[14:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 5'd1;
                end else begin
                    r_dacdat <= 1'b0;
                end
            end
        end
    end

    assign AUD_DACDAT = r_dacdat;
    assign SRAM_ADDR  = r_addr;
    assign SRAM_CE    = r_sram_off;
    assign SRAM_OE    = r_sram_off;
    assign SRAM_LB    = r_sram_off;
    assign SRAM_UB    = r_sram_off;
    assign SRAM_WE    = 1'b1;

endmodule

// File: tb/tb_playback.sv
// Bench for playback: expected DAC bits are queued per slot, a monitor compares them at each BCLK rise.
module tb_playback;

    logic        clk;
    logic        reset;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ;
    logic        SRAM_OE;
    logic        SRAM_WE;
    logic        SRAM_CE;
    logic        SRAM_LB;
    logic        SRAM_UB;
    logic [19:0] end_addr;
    logic        play_btn;
    logic        stop_btn;

    logic [15:0] mem [16];
    logic        exp_q [$];
    int          n_vec;
    int          n_bad;
    int          n_bits;
    int          fcnt;
    event        ev_lr_fall;
    event        ev_lr_rise;

    playback dut (
        .clk         (clk),
        .reset       (reset),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ     (SRAM_DQ),
        .SRAM_OE     (SRAM_OE),
        .SRAM_WE     (SRAM_WE),
        .SRAM_CE     (SRAM_CE),
        .SRAM_LB     (SRAM_LB),
        .SRAM_UB     (SRAM_UB),
        .end_addr    (end_addr),
        .play_btn    (play_btn),
        .stop_btn    (stop_btn)
    );

    assign SRAM_DQ = (SRAM_ADDR < 20'd16) ? mem[SRAM_ADDR[3:0]] : 16'hDEAD;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BCLK = clk/16, LRCK toggles every 32 BCLK falls; edges offset from clk edges.
    initial begin
        AUD_BCLK    = 1'b1;
        AUD_DACLRCK = 1'b1;
        fcnt        = 0;
        #2;
        forever begin
            #80;
            AUD_BCLK = 1'b0;
            fcnt++;
            if (fcnt % 32 == 0) begin
                AUD_DACLRCK = ~AUD_DACLRCK;
                if (AUD_DACLRCK == 1'b0) -> ev_lr_fall;
                else -> ev_lr_rise;
            end
            #80;
            AUD_BCLK = 1'b1;
        end
    end

    always @(posedge AUD_BCLK) begin : monitor
        logic e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            n_bits++;
            if (AUD_DACDAT !== e) begin
                n_bad++;
                $display("FAIL dacdat sample %0d: got %b want %b", n_bits, AUD_DACDAT, e);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_slot(input logic [15:0] w);
        exp_q.push_back(1'b0);
        for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
        for (int i = 0; i < 15; i++) exp_q.push_back(1'b0);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain timeout: %0d samples left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic play_press();
        @(ev_lr_rise);
        @(negedge clk);
        play_btn = 1'b0;
        repeat (4) @(negedge clk);
        play_btn = 1'b1;
    endtask

    task automatic stop_press();
        @(negedge clk);
        stop_btn = 1'b0;
        @(negedge clk);
        stop_btn = 1'b1;
    endtask

    function automatic logic [4:0] strobes();
        return {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB};
    endfunction

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        n_bits   = 0;
        reset    = 1'b1;
        play_btn = 1'b1;
        stop_btn = 1'b1;
        end_addr = 20'd3;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

        repeat (3) @(negedge clk);
        chk("reset dacdat", {31'd0, AUD_DACDAT}, 32'd0);
        chk("reset addr", {12'd0, SRAM_ADDR}, 32'd0);
        chk("reset strobes", {27'd0, strobes()}, 32'h1F);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle strobes", {27'd0, strobes()}, 32'h1F);

        // A5C3 in the left slot, silent right slot.
        mem[0] = 16'hA5C3;
        play_press();
        @(ev_lr_fall);
        push_slot(16'hA5C3);
        push_slot(16'h0000);
        drain();
        stop_press();

        // Four-word recording, end_addr = 3.
        mem[0] = 16'h8001;
        mem[1] = 16'h7FFE;
        mem[2] = 16'h1357;
        mem[3] = 16'h2468;
        mem[4] = 16'hFFFF;
        play_press();
        @(ev_lr_fall);
        push_slot(16'h8001);
        push_slot(16'h7FFE);
        push_slot(16'h1357);
        push_slot(16'h2468);
`ifdef PLAYBACK_LOOP_EN
        push_slot(16'h8001);
        push_slot(16'h7FFE);
`else
        push_zeros(64);
`endif
        #60;
        chk("addr after slot1", {12'd0, SRAM_ADDR}, 32'd1);
        chk("play strobes", {27'd0, strobes()}, 32'h04);
        @(ev_lr_rise);
        #60;
        chk("addr after slot2", {12'd0, SRAM_ADDR}, 32'd2);
        @(ev_lr_fall);
        #60;
        chk("addr after slot3", {12'd0, SRAM_ADDR}, 32'd3);
        @(ev_lr_rise);
        #60;
`ifdef PLAYBACK_LOOP_EN
        chk("addr after end slot", {12'd0, SRAM_ADDR}, 32'd0);
`else
        chk("addr after end slot", {12'd0, SRAM_ADDR}, 32'd3);
`endif
        @(ev_lr_fall);
        #60;
`ifdef PLAYBACK_LOOP_EN
        chk("addr slot5", {12'd0, SRAM_ADDR}, 32'd1);
        chk("strobes slot5", {27'd0, strobes()}, 32'h04);
`else
        chk("addr slot5", {12'd0, SRAM_ADDR}, 32'd0);
        chk("strobes slot5", {27'd0, strobes()}, 32'h1F);
`endif
        drain();
        stop_press();

        // Stop in the middle of a word.
        mem[0] = 16'hFFFF;
        mem[1] = 16'hFFFF;
        play_press();
        @(ev_lr_fall);
        push_zeros(1);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
        drain();
        @(negedge AUD_BCLK);
        #50;
        chk("bit7 before stop", {31'd0, AUD_DACDAT}, 32'd1);
        @(negedge clk);
        stop_btn = 1'b0;
        @(posedge clk);
        #1;
        chk("stop dacdat", {31'd0, AUD_DACDAT}, 32'd0);
        chk("stop ce", {31'd0, SRAM_CE}, 32'd1);
        chk("stop addr", {12'd0, SRAM_ADDR}, 32'd0);
        @(negedge clk);
        stop_btn = 1'b1;

        // Play and stop pressed together: stop wins.
        @(negedge clk);
        play_btn = 1'b0;
        stop_btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("both pressed strobes", {27'd0, strobes()}, 32'h1F);
        play_btn = 1'b1;
        stop_btn = 1'b1;
        push_zeros(64);
        drain();

        // Reset pulse mid-slot.
        play_press();
        @(ev_lr_fall);
        push_zeros(1);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
        drain();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset dacdat", {31'd0, AUD_DACDAT}, 32'd0);
        chk("midreset strobes", {27'd0, strobes()}, 32'h1F);
        chk("midreset addr", {12'd0, SRAM_ADDR}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        push_zeros(96);
        drain();

        // Fresh start after reset.
        mem[0] = 16'h5A0F;
        mem[1] = 16'h0000;
        play_press();
        @(ev_lr_fall);
        push_slot(16'h5A0F);
        push_slot(16'h0000);
        drain();
        stop_press();
        repeat (2) @(negedge clk);
        chk("final strobes", {27'd0, strobes()}, 32'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
